// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default widths of a register write
//   REG_ZERO                : register address that ZERO_GUARD suppresses
//   SRC_ALU / SRC_MEM       : source IDs reported on rf_src
//   sel_e                   : per-cycle issue decision of the arbiter
package regfile_wr_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned REG_ZERO   = 0;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef enum logic [1:0] {
    SelNone,
    SelAlu,
    SelMem
  } sel_e;

  // Source ID that corresponds to an issue decision (SelNone maps to ALU, unused).
  function automatic logic sel_to_src(input sel_e sel);
    return (sel == SelMem) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_hold_buf.sv
// One-entry writeback holding buffer (module wb_hold_buf).
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture in_addr/in_data (only asserted while empty)
//   drain             : empty the entry (only asserted while full)
//   in_addr, in_data  : incoming register write
//   full              : entry holds a pending write
//   addr, data        : contents of the pending write
module wb_hold_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // load and drain are mutually exclusive: load needs empty, drain needs full.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (drain) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      addr_d = in_addr;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbiter sharing the register file's single write port between the ALU
// writeback (req0) and the load writeback (req1).
//   clk, rst                      : clock, synchronous active-high reset
//   req0_valid/addr/data, _ready  : ALU write request and handshake
//   req1_valid/addr/data, _ready  : load write request and handshake
//   rf_hold                       : freeze issue (buffers may still fill)
//   rf_write, rf_addr, rf_data    : registered write port to the register file
//   rf_src                        : source of the current write (0 = req0, 1 = req1)
//   busy                          : a buffer is full or a write is being presented
// Oldest pending write issues first; equal-age writes alternate round-robin.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rf_hold,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_src,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              load0, load1;
  logic              drain0, drain1;

  // age_diff_q: the two full buffers were loaded on different edges;
  // age_old_q: which of them is older (only meaningful with age_diff_q).
  logic age_diff_q, age_diff_d;
  logic age_old_q, age_old_d;
  logic rr_q, rr_d;

  sel_e              sel;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              wr_d;

  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              rf_src_q, rf_src_d;

  // Ready comes from registered state only, so a drained buffer refills a cycle later.
  assign load0 = req0_valid & ~full0;
  assign load1 = req1_valid & ~full1;

  wb_hold_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .load    (load0),
    .drain   (drain0),
    .in_addr (req0_addr),
    .in_data (req0_data),
    .full    (full0),
    .addr    (addr0),
    .data    (data0)
  );

  wb_hold_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .load    (load1),
    .drain   (drain1),
    .in_addr (req1_addr),
    .in_data (req1_data),
    .full    (full1),
    .addr    (addr1),
    .data    (data1)
  );

  // Issue selection; the pointer only advances on an equal-age tie.
  always_comb begin
    sel  = SelNone;
    rr_d = rr_q;
    if (!rf_hold) begin
      if (full0 && !full1) begin
        sel = SelAlu;
      end else if (full1 && !full0) begin
        sel = SelMem;
      end else if (full0 && full1) begin
        if (age_diff_q) begin
          sel = (age_old_q == SRC_MEM) ? SelMem : SelAlu;
        end else begin
          sel  = (rr_q == SRC_MEM) ? SelMem : SelAlu;
          rr_d = ~rr_q;
        end
      end
    end
  end

  assign drain0 = (sel == SelAlu);
  assign drain1 = (sel == SelMem);

  always_comb begin
    win_addr = addr0;
    win_data = data0;
    unique case (sel)
      SelMem: begin
        win_addr = addr1;
        win_data = data1;
      end
      default: begin
        win_addr = addr0;
        win_data = data0;
      end
    endcase
  end

  // Age tracking. A buffer that stays full while the other loads is the older one.
  always_comb begin
    age_diff_d = age_diff_q;
    age_old_d  = age_old_q;
    if (load0 && load1) begin
      age_diff_d = 1'b0;
    end else if (load0 && full1 && !drain1) begin
      age_diff_d = 1'b1;
      age_old_d  = SRC_MEM;
    end else if (load1 && full0 && !drain0) begin
      age_diff_d = 1'b1;
      age_old_d  = SRC_ALU;
    end else if (drain0 || drain1) begin
      // At most one entry remains; age is rebuilt on the next load.
      age_diff_d = 1'b0;
    end
  end

  // Zero-address writes drain their buffer but never reach the register file.
  assign wr_d = (sel != SelNone) && !(ZERO_GUARD && (win_addr == ZeroAddr));

  always_comb begin
    rf_write_d = wr_d;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    rf_src_d   = rf_src_q;
    if (wr_d) begin
      rf_addr_d = win_addr;
      rf_data_d = win_data;
      rf_src_d  = sel_to_src(sel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_diff_q <= 1'b0;
      age_old_q  <= SRC_ALU;
      rr_q       <= SRC_ALU;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      rf_src_q   <= SRC_ALU;
    end else begin
      age_diff_q <= age_diff_d;
      age_old_q  <= age_old_d;
      rr_q       <= rr_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      rf_src_q   <= rf_src_d;
    end
  end

  assign req0_ready = ~full0;
  assign req1_ready = ~full1;
  assign rf_write   = rf_write_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign rf_src     = rf_src_q;
  assign busy       = full0 | full1 | rf_write_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a timestamp-based reference model
// pushes expected register writes into a queue; a monitor pops on rf_write.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rf_hold = 1'b0;
  logic [3:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, rf_write, rf_src, busy;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;

  // Second instance with ZERO_GUARD = 0, driven only by the zero-address test.
  logic        ng_valid = 1'b0;
  logic [3:0]  ng_addr = '0;
  logic [31:0] ng_data = '0;
  logic        ng_ready0, ng_ready1, ng_write, ng_src, ng_busy;
  logic [3:0]  ng_waddr;
  logic [31:0] ng_wdata;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(4), .ZERO_GUARD(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_hold    (rf_hold),
    .rf_write   (rf_write),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rf_src     (rf_src),
    .busy       (busy)
  );

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(4), .ZERO_GUARD(1'b0)) dut_ng (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (ng_valid),
    .req0_addr  (ng_addr),
    .req0_data  (ng_data),
    .req0_ready (ng_ready0),
    .req1_valid (1'b0),
    .req1_addr  (4'h0),
    .req1_data  (32'h0),
    .req1_ready (ng_ready1),
    .rf_hold    (1'b0),
    .rf_write   (ng_write),
    .rf_addr    (ng_waddr),
    .rf_data    (ng_wdata),
    .rf_src     (ng_src),
    .busy       (ng_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        src;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_full[2] = '{0, 0};
  logic [3:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_ts[2];
  int          m_rr = 0;
  int          m_cyc = 0;
  bit          m_out_wr = 0;
  logic [31:0] model_rf[16];
  logic [31:0] shadow_rf[16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_rf[i]  = '0;
      shadow_rf[i] = '0;
    end
  end

  always @(posedge clk) begin : model
    bit ld0, ld1;
    int w;
    exp_t e;
    m_cyc++;
    if (rst) begin
      m_full   = '{0, 0};
      m_rr     = 0;
      m_out_wr = 0;
    end else begin
      ld0 = req0_valid && !m_full[0];
      ld1 = req1_valid && !m_full[1];
      m_out_wr = 0;
      w = -1;
      if (!rf_hold) begin
        if (m_full[0] && m_full[1]) begin
          // Oldest by load time; simultaneous loads alternate.
          if (m_ts[0] < m_ts[1]) w = 0;
          else if (m_ts[1] < m_ts[0]) w = 1;
          else begin
            w = m_rr;
            m_rr = 1 - m_rr;
          end
        end else if (m_full[0]) w = 0;
        else if (m_full[1]) w = 1;
      end
      if (w >= 0) begin
        m_full[w] = 0;
        if (m_addr[w] != 4'd0) begin
          e.addr = m_addr[w];
          e.data = m_data[w];
          e.src  = (w == 1);
          exp_q.push_back(e);
          model_rf[m_addr[w]] = m_data[w];
          m_out_wr = 1;
        end
      end
      if (ld0) begin
        m_full[0] = 1; m_addr[0] = req0_addr; m_data[0] = req0_data; m_ts[0] = m_cyc;
      end
      if (ld1) begin
        m_full[1] = 1; m_addr[1] = req1_addr; m_data[1] = req1_data; m_ts[1] = m_cyc;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    check("req0_ready", 64'(req0_ready), 64'(!m_full[0]));
    check("req1_ready", 64'(req1_ready), 64'(!m_full[1]));
    check("busy", 64'(busy), 64'(m_full[0] || m_full[1] || m_out_wr));
    if (rf_write) begin
      shadow_rf[rf_addr] = rf_data;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({rf_addr, rf_data, rf_src}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data_src", 64'({rf_addr, rf_data, rf_src}), 64'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rf_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive0(input logic [3:0] a, input logic [31:0] d);
    req0_valid = 1'b1; req0_addr = a; req0_data = d;
  endtask

  task automatic drive1(input logic [3:0] a, input logic [31:0] d);
    req1_valid = 1'b1; req1_addr = a; req1_data = d;
  endtask

  task automatic expect_wr(input string name, input logic [3:0] a, input logic [31:0] d,
                           input logic s);
    check(name, 64'({rf_write, rf_addr, rf_data, rf_src}), 64'({1'b1, a, d, s}));
  endtask

  initial begin : main
    logic first_src;
    do_reset();
    check("reset_write", 64'(rf_write), 64'(0));
    check("reset_outputs", 64'({rf_addr, rf_data, rf_src, busy, req0_ready, req1_ready}),
          64'({4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1}));

    // 1: single write, 2-cycle latency
    drive0(4'd5, 32'd555);
    @(negedge clk); req0_valid = 1'b0;
    check("t1_no_early_write", 64'(rf_write), 64'(0));
    @(negedge clk); expect_wr("t1_write", 4'd5, 32'd555, 1'b0);
    @(negedge clk); check("t1_single_pulse", 64'(rf_write), 64'(0));
    #1 check("t1_reg5", 64'(shadow_rf[5]), 64'(555));

    // 2: simultaneous requests, round-robin alternates
    do_reset();
    drive0(4'd3, 32'd333); drive1(4'd7, 32'd777);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); expect_wr("t2_first_req0", 4'd3, 32'd333, 1'b0);
    @(negedge clk); expect_wr("t2_then_req1", 4'd7, 32'd777, 1'b1);
    drive0(4'd3, 32'd333); drive1(4'd7, 32'd777);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); expect_wr("t2_rr_req1", 4'd7, 32'd777, 1'b1);
    @(negedge clk); expect_wr("t2_rr_req0", 4'd3, 32'd333, 1'b0);

    // 3: same address, older write first under hold
    @(negedge clk);
    rf_hold = 1'b1;
    drive1(4'd4, 32'd11);
    @(negedge clk); req1_valid = 1'b0; drive0(4'd4, 32'd22);
    @(negedge clk); req0_valid = 1'b0;
    check("t3_held", 64'(rf_write), 64'(0));
    rf_hold = 1'b0;
    @(negedge clk); expect_wr("t3_older_first", 4'd4, 32'd11, 1'b1);
    @(negedge clk); expect_wr("t3_younger_second", 4'd4, 32'd22, 1'b0);
    #1 check("t3_reg4", 64'(shadow_rf[4]), 64'(22));

    // 4: zero-address guard
    @(negedge clk);
    drive0(4'd0, 32'hFFFF_FFFF);
    ng_valid = 1'b1; ng_addr = 4'd0; ng_data = 32'hFFFF_FFFF;
    @(negedge clk); req0_valid = 1'b0; ng_valid = 1'b0;
    check("t4_accepted", 64'(req0_ready), 64'(0));
    @(negedge clk);
    check("t4_ready_back", 64'(req0_ready), 64'(1));
    check("t4_no_write", 64'(rf_write), 64'(0));
    check("t4_ng_write", 64'({ng_write, ng_waddr, ng_wdata, ng_src}),
          64'({1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0}));
    @(negedge clk);
    check("t4_no_write_late", 64'(rf_write), 64'(0));
    check("t4_ng_single", 64'(ng_write), 64'(0));

    // 5: both full under hold for 4 cycles
    rf_hold = 1'b1;
    drive0(4'd1, 32'h11); drive1(4'd2, 32'h22);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_state", 64'({rf_write, req0_ready, req1_ready, busy}),
            64'({1'b0, 1'b0, 1'b0, 1'b1}));
      if (i < 3) @(negedge clk);
    end
    rf_hold = 1'b0;
    @(negedge clk);
    check("t5_write1", 64'(rf_write), 64'(1));
    first_src = rf_src;
    @(negedge clk);
    check("t5_write2", 64'({rf_write, rf_src}), 64'({1'b1, ~first_src}));

    // 6: reset while both full and a write is presented
    @(negedge clk);
    drive0(4'd8, 32'h88); drive1(4'd9, 32'h99);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_reset", 64'({rf_write, busy}), 64'({1'b1, 1'b1}));
    rst = 1'b1;
    @(negedge clk);
    check("t6_after_reset", 64'({rf_write, req0_ready, req1_ready, busy}),
          64'({1'b0, 1'b1, 1'b1, 1'b0}));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_ghost", 64'(rf_write), 64'(0));
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_addr  = 4'($urandom_range(0, 15));
      req0_data  = $urandom;
      req1_valid = 1'($urandom_range(0, 1));
      req1_addr  = 4'($urandom_range(0, 15));
      req1_data  = $urandom;
      rf_hold    = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rf_hold = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("drained_queue", 64'(exp_q.size()), 64'(0));
    for (int r = 0; r < 16; r++) begin
      check("final_regfile", 64'(shadow_rf[r]), 64'(model_rf[r]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
